fb_rect_writer: RTL

FB_RECT_WRITER -- requirements
Module: fb_rect_writer

---
 rtl/fb_pkg.sv | 8 +
 rtl/rect_clip.sv | 30 +++
 rtl/fb_rect_writer.sv | 104 ++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer geometry defaults and rectangle-writer state encoding
package fb_pkg;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int ADDR_W_DEF = 19;
  localparam int COLOR_W_DEF = 4;
  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;
endpackage

// File: rtl/rect_clip.sv
// rect_clip: combinational clipping of a rectangle command to the screen bounds
module rect_clip import fb_pkg::*; #(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic [9:0]  x0,
  input  logic [8:0]  y0,
  input  logic [9:0]  w,
  input  logic [8:0]  h,
  input  logic        clear,
  output logic [9:0]  bx0,
  output logic [8:0]  by0,
  output logic [10:0] xe,
  output logic [9:0]  ye,
  output logic        empty
);
  localparam logic [10:0] scr_w = 11'(SCREEN_W);
  localparam logic [9:0] scr_h = 10'(SCREEN_H);
  logic [10:0] xs;
  logic [9:0] ys;
  always_comb begin
    xs = {1'b0, x0} + {1'b0, w};
    ys = {1'b0, y0} + {1'b0, h};
    bx0 = clear ? '0 : x0;
    by0 = clear ? '0 : y0;
    xe = (clear || xs > scr_w) ? scr_w : xs;
    ye = (clear || ys > scr_h) ? scr_h : ys;
    empty = !clear && (w == '0 || h == '0 || {1'b0, x0} >= scr_w || {1'b0, y0} >= scr_h);
  end
endmodule

// File: rtl/fb_rect_writer.sv
// fb_rect_writer: fills a clipped rectangle (or the whole screen) with one framebuffer write per cycle
module fb_rect_writer import fb_pkg::*; #(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int COLOR_W = COLOR_W_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [9:0]         cmd_x0,
  input  logic [8:0]         cmd_y0,
  input  logic [9:0]         cmd_w,
  input  logic [8:0]         cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               cmd_clear,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               wr_en,
  output logic               busy,
  output logic               done
);
  localparam logic [ADDR_W-1:0] row_step = ADDR_W'(SCREEN_W);
  state_t state, state_n;
  logic [9:0] x0_r, w_r, bx0, bx0_r;
  logic [8:0] y0_r, h_r, by0;
  logic clear_r, empty, last, row_end;
  logic [COLOR_W-1:0] color_r;
  logic [10:0] xe, xe_r, x_r;
  logic [9:0] ye, ye_r, y_r;
  logic [ADDR_W-1:0] row_r, row0;

  function automatic logic [ADDR_W-1:0] times_w(input logic [8:0] y);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) acc = SCREEN_W[i] ? acc + (ADDR_W'(y) << i) : acc;
    return acc;
  endfunction

  rect_clip #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) u_clip (
    .x0(x0_r), .y0(y0_r), .w(w_r), .h(h_r), .clear(clear_r),
    .bx0(bx0), .by0(by0), .xe(xe), .ye(ye), .empty(empty)
  );

  always_comb begin
    row_end = x_r == xe_r - 11'd1;
    last = row_end && y_r == ye_r - 10'd1;
    row0 = times_w(by0);
    state_n = state == IDLE  ? (cmd_valid ? SETUP : IDLE) :
              state == SETUP ? (empty ? DONE : FILL) :
              state == FILL  ? (last ? DONE : FILL) : IDLE;
  end

  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign wr_en = state == FILL;
  assign done = state == DONE;

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x0_r <= '0;
      y0_r <= '0;
      w_r <= '0;
      h_r <= '0;
      clear_r <= 1'b0;
      color_r <= '0;
      bx0_r <= '0;
      xe_r <= '0;
      ye_r <= '0;
      x_r <= '0;
      y_r <= '0;
      row_r <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (state == IDLE && cmd_valid) begin
      x0_r <= cmd_x0;
      y0_r <= cmd_y0;
      w_r <= cmd_w;
      h_r <= cmd_h;
      clear_r <= cmd_clear;
      color_r <= cmd_color;
    end else if (state == SETUP && !empty) begin
      bx0_r <= bx0;
      xe_r <= xe;
      ye_r <= ye;
      x_r <= {1'b0, bx0};
      y_r <= {1'b0, by0};
      row_r <= row0;
      wr_addr <= row0 + ADDR_W'(bx0);
      wr_data <= color_r;
    end else if (state == FILL && !last) begin
      x_r <= row_end ? {1'b0, bx0_r} : x_r + 11'd1;
      y_r <= row_end ? y_r + 10'd1 : y_r;
      row_r <= row_end ? row_r + row_step : row_r;
      wr_addr <= row_end ? row_r + row_step + ADDR_W'(bx0_r) : wr_addr + ADDR_W'(1);
    end
  end
endmodule
